// File: rtl/score_digit_ctrl.sv
// score_digit_ctrl: 4-digit BCD score counter with serial add,
// frame-synchronous shadow copy and 4-slot glyph-renderer scheduling.
// Ports: clk, reset (async, active-high); inc/inc_amt add request;
//   clr sync clear; refresh_tick frame pulse; pixel_x/pixel_y beam pos;
//   busy, overflow, bcd_count status; digit_value/digit_x/digit_y/
//   digit_active drive the shared renderer.
// Option: define LEADING_ZERO_BLANK_EN to blank leading zero digits.
module score_digit_ctrl #(
  parameter logic [9:0] ORIGIN_X = 10'd16,
  parameter logic [9:0] ORIGIN_Y = 10'd16,
  parameter logic [9:0] PITCH    = 10'd20
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inc,
  input  logic [3:0]  inc_amt,
  input  logic        clr,
  input  logic        refresh_tick,
  input  logic [9:0]  pixel_x,
  input  logic [9:0]  pixel_y,
  output logic        busy,
  output logic        overflow,
  output logic [15:0] bcd_count,
  output logic [3:0]  digit_value,
  output logic [9:0]  digit_x,
  output logic [9:0]  digit_y,
  output logic        digit_active
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADD0,
    S_ADD1,
    S_ADD2,
    S_ADD3
  } state_t;

  state_t      r_state;
  state_t      w_state_nx;
  logic [15:0] r_count;
  logic [15:0] w_count_nx;
  logic [15:0] r_shadow;
  logic [15:0] w_shadow_nx;
  logic [3:0]  r_addend;
  logic [3:0]  w_addend_nx;
  logic        r_carry;
  logic        w_carry_nx;
  logic        r_pend;
  logic        w_pend_nx;
  logic        r_ovf;
  logic        w_ovf_nx;

  logic        w_accept;
  logic [1:0]  w_k;
  logic [3:0]  w_digit;
  logic [3:0]  w_add_in;
  logic [4:0]  w_sum;
  logic [3:0]  w_wr;
  logic        w_cout;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_count  <= 16'h0000;
      r_shadow <= 16'h0000;
      r_addend <= 4'd0;
      r_carry  <= 1'b0;
      r_pend   <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      r_state  <= w_state_nx;
      r_count  <= w_count_nx;
      r_shadow <= w_shadow_nx;
      r_addend <= w_addend_nx;
      r_carry  <= w_carry_nx;
      r_pend   <= w_pend_nx;
      r_ovf    <= w_ovf_nx;
    end
  end

  // One BCD digit adder shared by all four ADD states.
  always_comb begin
    w_k = 2'd0;
    unique case (r_state)
      S_ADD1:  w_k = 2'd1;
      S_ADD2:  w_k = 2'd2;
      S_ADD3:  w_k = 2'd3;
      default: w_k = 2'd0;
    endcase
    w_digit  = r_count[w_k*4 +: 4];
    w_add_in = (r_state == S_ADD0) ? r_addend : 4'd0;
    w_sum    = {1'b0, w_digit} + {1'b0, w_add_in} + {4'd0, r_carry};
    w_cout   = (w_sum > 5'd9);
    w_wr     = w_cout ? 4'(w_sum - 5'd10) : w_sum[3:0];
  end

  always_comb begin
    w_state_nx  = r_state;
    w_count_nx  = r_count;
    w_shadow_nx = r_shadow;
    w_addend_nx = r_addend;
    w_carry_nx  = r_carry;
    w_pend_nx   = r_pend;
    w_ovf_nx    = 1'b0;
    w_accept    = 1'b0;

    if (clr) begin
      w_state_nx  = S_IDLE;
      w_count_nx  = 16'h0000;
      w_shadow_nx = 16'h0000;
      w_carry_nx  = 1'b0;
      w_pend_nx   = 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (inc) begin
            w_accept    = 1'b1;
            w_addend_nx = (inc_amt > 4'd9) ? 4'd9 : inc_amt;
            w_carry_nx  = 1'b0;
            w_state_nx  = S_ADD0;
          end
        end
        S_ADD0, S_ADD1, S_ADD2: begin
          w_count_nx[w_k*4 +: 4] = w_wr;
          w_carry_nx             = w_cout;
          w_state_nx             = state_t'(r_state + 3'd1);
        end
        S_ADD3: begin
          w_count_nx[15:12] = w_wr;
          w_carry_nx        = 1'b0;
          w_ovf_nx          = w_cout;
          w_state_nx        = S_IDLE;
        end
        default: w_state_nx = S_IDLE;
      endcase

      // Copy only from a settled counter; otherwise remember the tick.
      if (r_state == S_IDLE && !w_accept) begin
        if (refresh_tick || r_pend) begin
          w_shadow_nx = r_count;
          w_pend_nx   = 1'b0;
        end
      end else if (refresh_tick) begin
        w_pend_nx = 1'b1;
      end
    end
  end

  assign busy      = (r_state != S_IDLE);
  assign overflow  = r_ovf;
  assign bcd_count = r_count;
  assign digit_y   = ORIGIN_Y;

  logic [9:0] w_ox;
  logic       w_in_y;
  logic       w_hit;
  logic       w_zero_run;
  logic       w_blank;
  logic [3:0] w_sd;

  // Slot k shows shadow digit 3-k; w_zero_run tracks whether every
  // digit from the most significant down to this one is zero.
  always_comb begin
    digit_value  = 4'd0;
    digit_x      = ORIGIN_X;
    digit_active = 1'b0;
    w_ox         = ORIGIN_X;
    w_hit        = 1'b0;
    w_sd         = 4'd0;
    w_blank      = 1'b0;
    w_zero_run   = 1'b1;
    w_in_y       = (pixel_y >= ORIGIN_Y) &&
                   (pixel_y <= ORIGIN_Y + 10'd15);
    for (int k = 0; k < 4; k++) begin
      w_ox       = ORIGIN_X + 10'(k) * PITCH;
      w_hit      = w_in_y && (pixel_x >= w_ox) &&
                   (pixel_x <= w_ox + 10'd15);
      w_sd       = r_shadow[(3-k)*4 +: 4];
      w_zero_run = w_zero_run && (w_sd == 4'd0);
`ifdef LEADING_ZERO_BLANK_EN
      w_blank    = w_zero_run && (k != 3);
`else
      w_blank    = 1'b0;
`endif
      if (w_hit) begin
        digit_value  = w_sd;
        digit_x      = w_ox;
        digit_active = !w_blank;
      end
    end
  end

endmodule

// File: tb/tb_score_digit_ctrl.sv
// tb_score_digit_ctrl: randomized and directed stimulus against an
// integer-level reference model of the score counter and slot decode.
module tb_score_digit_ctrl;

  localparam int OX = 16;
  localparam int OY = 16;
  localparam int PT = 20;

  logic        clk;
  logic        reset;
  logic        inc;
  logic [3:0]  inc_amt;
  logic        clr;
  logic        refresh_tick;
  logic [9:0]  pixel_x;
  logic [9:0]  pixel_y;
  logic        busy;
  logic        overflow;
  logic [15:0] bcd_count;
  logic [3:0]  digit_value;
  logic [9:0]  digit_x;
  logic [9:0]  digit_y;
  logic        digit_active;

  score_digit_ctrl dut (
    .clk(clk),
    .reset(reset),
    .inc(inc),
    .inc_amt(inc_amt),
    .clr(clr),
    .refresh_tick(refresh_tick),
    .pixel_x(pixel_x),
    .pixel_y(pixel_y),
    .busy(busy),
    .overflow(overflow),
    .bcd_count(bcd_count),
    .digit_value(digit_value),
    .digit_x(digit_x),
    .digit_y(digit_y),
    .digit_active(digit_active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk;
  int n_fail;

  // Reference model: plain integers.
  int m_cnt;
  int m_sh;
  int m_pend;
  int m_rem;
  int m_res;
  int m_ovf;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp,
               $time);
    end
  endtask

  function automatic int pow10(input int e);
    int r;
    r = 1;
    for (int i = 0; i < e; i++) r = r * 10;
    return r;
  endfunction

  function automatic int to_bcd(input int v);
    return ((v / 1000) % 10) * 4096 + ((v / 100) % 10) * 256 +
           ((v / 10) % 10) * 16 + (v % 10);
  endfunction

  task automatic model_reset();
    m_cnt  = 0;
    m_sh   = 0;
    m_pend = 0;
    m_rem  = 0;
    m_res  = 0;
    m_ovf  = 0;
  endtask

  task automatic model_edge(input bit a_inc, input int a_amt,
                            input bit a_clr, input bit a_tick);
    bit acc;
    int nx_ovf;
    if (a_clr) begin
      model_reset();
      return;
    end
    nx_ovf = 0;
    acc = (m_rem == 0) && a_inc;
    if (m_rem == 0 && !acc) begin
      if (a_tick || m_pend != 0) begin
        m_sh   = m_cnt;
        m_pend = 0;
      end
    end else if (a_tick) begin
      m_pend = 1;
    end
    if (acc) begin
      m_rem = 4;
      m_res = m_cnt + ((a_amt > 9) ? 9 : a_amt);
    end else if (m_rem > 0) begin
      m_rem--;
      if (m_rem == 0) begin
        m_cnt  = m_res % 10000;
        nx_ovf = (m_res >= 10000) ? 1 : 0;
      end
    end
    m_ovf = nx_ovf;
  endtask

  task automatic compare_all();
    int px;
    int py;
    int dx;
    int slot;
    int ev;
    int ex;
    int ea;
    px = int'(pixel_x);
    py = int'(pixel_y);
    slot = -1;
    check("busy", int'(busy), (m_rem != 0) ? 1 : 0);
    check("overflow", int'(overflow), m_ovf);
    if (m_rem == 0) check("bcd_count", int'(bcd_count), to_bcd(m_cnt));
    if (px >= OX && py >= OY && py <= OY + 15) begin
      dx = px - OX;
      if (dx < 4 * PT && (dx % PT) < 16) slot = dx / PT;
    end
    if (slot < 0) begin
      ev = 0;
      ex = OX;
      ea = 0;
    end else begin
      ev = (m_sh / pow10(3 - slot)) % 10;
      ex = OX + slot * PT;
      ea = 1;
`ifdef LEADING_ZERO_BLANK_EN
      if (slot < 3 && m_sh < pow10(3 - slot)) ea = 0;
`endif
    end
    check("digit_value", int'(digit_value), ev);
    check("digit_x", int'(digit_x), ex);
    check("digit_y", int'(digit_y), OY);
    check("digit_active", int'(digit_active), ea);
  endtask

  task automatic step(input bit a_inc, input int a_amt,
                      input bit a_clr, input bit a_tick);
    inc          = a_inc;
    inc_amt      = 4'(a_amt);
    clr          = a_clr;
    refresh_tick = a_tick;
    @(posedge clk);
    model_edge(a_inc, a_amt, a_clr, a_tick);
    #1;
    inc          = 1'b0;
    clr          = 1'b0;
    refresh_tick = 1'b0;
    compare_all();
  endtask

  task automatic do_inc(input int amt);
    step(1'b1, amt, 1'b0, 1'b0);
    repeat (4) step(1'b0, 0, 1'b0, 1'b0);
  endtask

  task automatic load(input int v);
    int r;
    int a;
    r = v;
    step(1'b0, 0, 1'b1, 1'b0);
    while (r > 0) begin
      a = (r > 9) ? 9 : r;
      do_inc(a);
      r -= a;
    end
    step(1'b0, 0, 1'b0, 1'b1);
  endtask

  task automatic set_pix(input int x, input int y);
    pixel_x = 10'(x);
    pixel_y = 10'(y);
  endtask

  initial begin
    n_chk        = 0;
    n_fail       = 0;
    inc          = 1'b0;
    inc_amt      = 4'd0;
    clr          = 1'b0;
    refresh_tick = 1'b0;
    set_pix(76, 20);
    model_reset();
    reset = 1'b1;
    #12;
    compare_all();
    reset = 1'b0;
    step(1'b0, 0, 1'b0, 1'b0);

    // 0000 + 7, then refresh after busy; slot 3 should show 7.
    do_inc(7);
    step(1'b0, 0, 1'b0, 1'b1);
    check("slot3_seven", int'(digit_value), 7);

    // Clamp: 0000 + 15 -> 0009.
    load(0);
    do_inc(15);
    check("clamp", int'(bcd_count), 16'h0009);

    // Wrap: 9995 + 9 -> 0004 with a one-cycle overflow.
    load(9995);
    step(1'b1, 9, 1'b0, 1'b0);
    repeat (3) step(1'b0, 0, 1'b0, 1'b0);
    step(1'b0, 0, 1'b0, 1'b0);
    check("wrap_ovf", int'(overflow), 1);
    check("wrap_cnt", int'(bcd_count), 16'h0004);
    step(1'b0, 0, 1'b0, 1'b0);
    check("ovf_one_cycle", int'(overflow), 0);

    // Refresh during ADD1 of 0199 + 1.
    set_pix(OX + 2 * PT + 3, 20);
    load(199);
    step(1'b1, 1, 1'b0, 1'b0);
    step(1'b0, 0, 1'b0, 1'b1);
    step(1'b0, 0, 1'b0, 1'b0);
    step(1'b0, 0, 1'b0, 1'b0);
    step(1'b0, 0, 1'b0, 1'b0);
    check("no_tear", int'(digit_value), 9);
    step(1'b0, 0, 1'b0, 1'b0);
    check("tear_copy", int'(digit_value), 0);

    // Slot decode around shadow 0042.
    load(42);
    set_pix(76, 20);
    step(1'b0, 0, 1'b0, 1'b0);
    check("px76_val", int'(digit_value), 2);
    set_pix(33, 20);
    step(1'b0, 0, 1'b0, 1'b0);
    check("px33_gap", int'(digit_active), 0);
    set_pix(16, 20);
    step(1'b0, 0, 1'b0, 1'b0);

    // clr with inc at 1234.
    load(1234);
    step(1'b1, 5, 1'b1, 1'b0);
    check("clr_cnt", int'(bcd_count), 0);
    check("clr_busy", int'(busy), 0);

    // Random traffic.
    for (int i = 0; i < 20000; i++) begin
      set_pix($urandom_range(0, 120), $urandom_range(10, 36));
      step(($urandom_range(0, 1) == 1),
           $urandom_range(0, 15),
           ($urandom_range(0, 199) == 0),
           ($urandom_range(0, 7) == 0));
    end

    // Async reset while in ADD2 of 0998 + 5.
    load(998);
    step(1'b1, 5, 1'b0, 1'b0);
    step(1'b0, 0, 1'b0, 1'b0);
    step(1'b0, 0, 1'b0, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check("rst_cnt", int'(bcd_count), 0);
    check("rst_busy", int'(busy), 0);
    compare_all();
    #2;
    reset = 1'b0;
    step(1'b0, 0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/score_digit_ctrl.md
Name: score_digit_ctrl

Overview:
- Owns a 4-digit BCD score counter and schedules one shared 16x16 glyph-renderer instance across four on-screen digit slots.
- Accepts add requests from game logic and performs a serial BCD add, one digit per cycle.
- Holds a frame-synchronous shadow copy so the displayed value never tears mid-frame.
- For each pixel, drives the renderer's value and top-left inputs for whichever slot contains that pixel.

Parameters:
ORIGIN_X, 10'd16, x of leftmost (most significant) slot's top-left pixel
ORIGIN_Y, 10'd16, y of all slots' top-left pixel
PITCH, 10'd20, horizontal distance between slot origins; must be >= 16; ORIGIN_X+3*PITCH+15 must be <= 639

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
inc  in  1  add request strobe; accepted only when busy=0
inc_amt  in  4  addend 0..9; values >9 are clamped to 9
clr  in  1  synchronous clear of counter and shadow
refresh_tick  in  1  one-cycle pulse at frame start (vsync-derived)
pixel_x  in  10  current pixel column
pixel_y  in  10  current pixel row
busy  out  1  serial add in progress
overflow  out  1  one-cycle pulse when count wraps past 9999
bcd_count  out  16  live counter, {d3,d2,d1,d0}, d3 most significant
digit_value  out  4  shadow digit for the selected slot, to the renderer's value input
digit_x  out  10  selected slot's top-left x, to the renderer
digit_y  out  10  equals ORIGIN_Y
digit_active  out  1  pixel lies inside a slot and that slot is not blanked; AND with the renderer's on output

Behaviour:
- Reset (asynchronous) values:
  - state IDLE; counter 0000; shadow 0000; refresh_pending 0
  - busy 0, overflow 0
  - digit_value/digit_x/digit_active follow the combinational decode of the zero shadow
- FSM states: IDLE, ADD0, ADD1, ADD2, ADD3.
  - IDLE: inc=1 at edge t: latch min(inc_amt,9) as addend and clear the carry; ADD0 at t+1.
  - ADDk: sum = dk + (k==0 ? addend : 0) + carry.
    - If sum>9: dk <= sum-10, carry <= 1. Else dk <= sum, carry <= 0.
    - Next state is ADD(k+1); ADD3 goes to IDLE.
  - Always 4 cycles; no early exit. busy = (state != IDLE), so high exactly 4 cycles per accepted inc.
- Overflow: if the carry out of ADD3 is 1, the counter wraps modulo 10000 and overflow is high for the single cycle after the ADD3 edge.
- inc while busy=1: ignored, no queueing; the requester must hold or retry.
- clr:
  - Highest priority in every state.
  - Next edge: counter 0000, shadow 0000, state IDLE, carry 0, refresh_pending 0, overflow 0.
  - An inc in the same cycle as clr is dropped.
- Shadow update:
  - In IDLE with (refresh_tick | refresh_pending) and no inc accepted that cycle: shadow <= counter, refresh_pending <= 0.
  - refresh_tick while busy, or in the same cycle an inc is accepted: set refresh_pending. The copy happens on the first IDLE cycle with no new inc, so a partially added value is never captured.
- Slot decode (combinational, zero latency from pixel_x/pixel_y and the shadow):
  - Slot k (k=0..3, k=0 leftmost, shows d(3-k)) spans x in [ORIGIN_X+k*PITCH, ORIGIN_X+k*PITCH+15] and y in [ORIGIN_Y, ORIGIN_Y+15].
  - In a slot: digit_x = slot origin, digit_value = that shadow digit, in-slot = 1.
  - Outside all slots: digit_value=0, digit_x=ORIGIN_X, digit_active=0.
  - Gap pixels between slots are outside; there is no overlap because PITCH >= 16.
- All arithmetic is 4-bit per digit; the sum fits in 5 bits (max 9+9+1=19).

Optional Feature:
- Macro LEADING_ZERO_BLANK_EN.
- Defined: digit_active is forced 0 for a slot whose shadow digit and all more-significant shadow digits are 0. The least-significant slot is never blanked, so 0000 renders as a single "0" in slot 3.
- Undefined: digit_active = in-slot; all four digits always render, including leading zeros.

Test Plan:
- Reset mid-ADD2 (count 0998, inc_amt=5 accepted) -> all outputs immediately reset values, bcd_count=0000, busy=0.
- Count 0000, inc with inc_amt=7, then refresh_tick after busy falls -> busy high exactly 4 cycles, bcd_count=0007, shadow/digit_value at slot 3 = 7.
- Count 9995, inc_amt=9 -> bcd_count=0004 after 4 busy cycles, overflow high exactly 1 cycle after the ADD3 edge. Also inc_amt=15 from 0000 -> 0009 (clamp).
- refresh_tick during ADD1 of 0199+1 -> shadow stays 0199 during busy, becomes 0200 on the first IDLE cycle; never shows 0190/0100.
- Shadow 0042, ORIGIN_X=16, PITCH=20, pixel_y=20:
  - pixel_x=76 -> digit_x=76, digit_value=2, digit_active=1.
  - pixel_x=33 (gap) -> digit_active=0.
  - pixel_x=16 -> digit_active=0 with LEADING_ZERO_BLANK_EN defined; 1 (digit_value=0) without it.
- clr asserted in the same cycle as inc while count=1234 -> next cycle count 0000, shadow 0000, busy=0, no add performed.
